micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have port `clk`, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port `rst`, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port `start`, input, 1 bit: leave IDLE and begin microcode execution.
REQ-005 SHALL have port `stall`, input, 1 bit: memory wait; holds the current microinstruction in EXEC.
REQ-006 SHALL have port `cs_data`, input, 36 bits: control-store word at `mpc`, read combinationally.
REQ-007 SHALL have port `N`, input, 1 bit: ULA negative flag for the current select.
REQ-008 SHALL have port `Z`, input, 1 bit: ULA zero flag for the current select.
REQ-009 SHALL have port `mbr`, input, 8 bits: opcode byte for JMPC.
REQ-010 SHALL have port `mpc`, output, 9 bits: control-store address.
REQ-011 SHALL have port `select`, output, 8 bits: ULA/shifter select {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}.
REQ-012 SHALL have port `c_en`, output, 9 bits: register write enables.
REQ-013 SHALL have port `mem`, output, 3 bits: {WRITE,READ,FETCH} strobes.
REQ-014 SHALL have port `b_sel`, output, 4 bits: B-bus source code.
REQ-015 SHALL have port `n_flag`, output, 1 bit: latched N.
REQ-016 SHALL have port `z_flag`, output, 1 bit: latched Z.
REQ-017 SHALL have port `halted`, output, 1 bit: sequencer is in HALT.
REQ-018 SHALL have port `ucount`, output, 32 bits: count of retired microinstructions.

Function
REQ-019 MIR layout SHALL be [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ, [23:16] ALU, [15:7] C, [6:4] MEM, [3:0] B.
REQ-020 SHALL implement states IDLE, FETCH, EXEC and HALT.
REQ-021 IDLE SHALL go to FETCH on the edge where start=1; otherwise it stays in IDLE.
REQ-022 FETCH SHALL load MIR <= cs_data and go to EXEC unconditionally, in exactly 1 cycle.
REQ-023 In EXEC, `select` SHALL equal MIR[23:16].
REQ-024 Outside EXEC, `select` SHALL be 8'b00010000 (ULA constant 0).
REQ-025 In EXEC with stall=0, `c_en` SHALL equal MIR[15:7] and `mem` SHALL equal MIR[6:4].
REQ-026 Outside EXEC, or with stall=1, `c_en` and `mem` SHALL be 0.
REQ-027 `b_sel` SHALL equal MIR[3:0] at all times.
REQ-028 An EXEC edge with stall=1 SHALL change no state: MIR, mpc, flags, ucount and the FSM state all hold, for any number of cycles.
REQ-029 An EXEC edge with stall=0 SHALL perform all of the following on the same edge:
- n_flag <= N and z_flag <= Z;
- ucount <= ucount+1, wrapping from 0xFFFFFFFF to 0;
- mpc <= next address (REQ-030);
- state <= FETCH, or HALT when MIR[35:27]==9'h1FF and MIR[26:24]==0.
REQ-030 The next address SHALL be computed as:
- mpc[8] = NA[8] | (JAMN & N) | (JAMZ & Z), using the live N/Z inputs, not the latched flags;
- mpc[7:0] = NA[7:0] | (JMPC ? mbr : 8'h00).
REQ-031 One microinstruction SHALL take 2 cycles (FETCH + EXEC) plus any stall cycles.
REQ-032 HALT SHALL hold halted=1, keep all registers frozen, and ignore start and stall; only rst exits HALT.
REQ-033 start SHALL be ignored in every state except IDLE.

Reset
REQ-034 On rst=1 SHALL asynchronously clear:
- state <= IDLE;
- mpc, MIR, ucount <= 0;
- n_flag, z_flag, halted <= 0.
REQ-035 On rst=1 the outputs SHALL become select=8'b00010000 and c_en=mem=0 immediately.
REQ-036 Reset asserted mid-EXEC, including during stall, SHALL discard the in-flight microinstruction with no c_en or mem pulse.

Configuration
REQ-037 With macro MICRO_SEQUENCER_JMPC_EN defined, JMPC SHALL OR `mbr` into mpc[7:0] as in REQ-030.
REQ-038 Without MICRO_SEQUENCER_JMPC_EN, MIR[26] SHALL be ignored (treated as 0), `mbr` SHALL be unused, and the HALT test SHALL check MIR[25:24] only.

Verification
REQ-039 Reset then start: control store returns NA=9'h005, ALU=8'b00111100, C=9'h001 at mpc 0 → select=00111100 and c_en=001 in cycle 2, mpc=5 after cycle 2, ucount=1.
REQ-040 JAMZ branch: NA=9'h010, JAMZ=1, Z=1 → mpc=9'h110; the same word with Z=0 → mpc=9'h010 and z_flag=0.
REQ-041 JMPC (macro defined): NA=9'h000, JMPC=1, mbr=8'h60 → mpc=9'h060; with the macro undefined → mpc=9'h000.
REQ-042 Stall: stall=1 for 3 EXEC cycles → c_en=0, mem=0, and mpc/ucount unchanged throughout; release → one commit only, ucount +1.
REQ-043 HALT: NA=9'h1FF, JAM=0 → halted=1 after the EXEC edge, mpc stays 9'h1FF, and start pulses have no effect; rst → halted=0, mpc=0.
REQ-044 Async reset mid-EXEC: assert rst between clock edges → select=00010000, c_en=0, ucount=0 before the next edge.

Source files
------------

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//
// Microprogram sequencer for a MIC-1 style datapath. Each microinstruction
// takes a FETCH cycle (control-store word latched into MIR) and an EXEC
// cycle (control outputs driven, next address and flags committed).
//
// MIR layout: [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ,
//             [23:16] ALU select, [15:7] C enables, [6:4] MEM, [3:0] B.
//
// Optional feature: define MICRO_SEQUENCER_JMPC_EN to let JMPC OR the mbr
// opcode byte into mpc[7:0]. Without it, MIR[26] and mbr are ignored and
// the HALT test looks at JAMN/JAMZ only.
//
// Handshake: start is sampled only in IDLE (one-cycle pulse suffices).
// stall is a wait request valid only in EXEC: while stall=1 the current
// microinstruction is held with c_en/mem suppressed and nothing commits;
// the first EXEC edge with stall=0 commits it exactly once.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        leave IDLE and begin execution
//   stall        memory wait, holds the current microinstruction in EXEC
//   cs_data      control-store word at mpc (combinational read)
//   N, Z         live ULA flags
//   mbr          opcode byte for JMPC
//   mpc          control-store address
//   select       ULA/shifter select {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}
//   c_en         register write enables
//   mem          {WRITE,READ,FETCH} strobes
//   b_sel        B-bus source code
//   n_flag,z_flag latched flags
//   halted       sequencer is in HALT
//   ucount       retired microinstruction count
//   state_dbg    current FSM state (debug)
// ---------------------------------------------------------------------------
module micro_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic [35:0] cs_data,
  input  logic        N,
  input  logic        Z,
  input  logic [7:0]  mbr,
  output logic [8:0]  mpc,
  output logic [7:0]  select,
  output logic [8:0]  c_en,
  output logic [2:0]  mem,
  output logic [3:0]  b_sel,
  output logic        n_flag,
  output logic        z_flag,
  output logic        halted,
  output logic [31:0] ucount,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // ULA select that produces the constant 0 (ENA/ENB low, F1 high).
  localparam logic [7:0] SEL_ZERO = 8'b0001_0000;
  localparam logic [8:0] HALT_NA  = 9'h1FF;

  state_e      state_q, state_d;
  logic [35:0] mir_q, mir_d;
  logic [8:0]  mpc_q, mpc_d;
  logic [31:0] ucount_q, ucount_d;
  logic        n_flag_q, n_flag_d;
  logic        z_flag_q, z_flag_d;
  logic        halted_q, halted_d;

  logic [8:0]  na;
  logic        jamn;
  logic        jamz;
  logic [7:0]  jmpc_mask;
  logic        halt_hit;
  logic [8:0]  next_addr;
  logic        in_exec;
  logic        commit;

  assign na   = mir_q[35:27];
  assign jamn = mir_q[25];
  assign jamz = mir_q[24];

`ifdef MICRO_SEQUENCER_JMPC_EN
  assign jmpc_mask = mir_q[26] ? mbr : 8'h00;
  assign halt_hit  = (na == HALT_NA) && (mir_q[26:24] == 3'b000);
`else
  // JMPC bit and mbr are deliberately ignored in this build.
  logic unused_jmpc;
  assign unused_jmpc = ^{mir_q[26], mbr};
  assign jmpc_mask   = 8'h00;
  assign halt_hit    = (na == HALT_NA) && (mir_q[25:24] == 2'b00);
`endif

  // Branch uses the live N/Z of the current select, not the latched flags.
  assign next_addr = {na[8] | (jamn & N) | (jamz & Z), na[7:0] | jmpc_mask};

  assign in_exec = (state_q == ST_EXEC);
  assign commit  = in_exec & ~stall;

  always_comb begin
    state_d  = state_q;
    mir_d    = mir_q;
    mpc_d    = mpc_q;
    ucount_d = ucount_q;
    n_flag_d = n_flag_q;
    z_flag_d = z_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mir_d   = cs_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!stall) begin
          n_flag_d = N;
          z_flag_d = Z;
          ucount_d = ucount_q + 32'd1;
          mpc_d    = next_addr;
          state_d  = halt_hit ? ST_HALT : ST_FETCH;
        end
      end
      default: ;  // ST_HALT: frozen until reset
    endcase
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mir_q    <= '0;
      mpc_q    <= '0;
      ucount_q <= '0;
      n_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mir_q    <= mir_d;
      mpc_q    <= mpc_d;
      ucount_q <= ucount_d;
      n_flag_q <= n_flag_d;
      z_flag_q <= z_flag_d;
      halted_q <= halted_d;
    end
  end

  // Control outputs derive from registered state so reset clears them
  // immediately; c_en/mem are also gated by the live stall.
  assign select    = in_exec ? mir_q[23:16] : SEL_ZERO;
  assign c_en      = commit ? mir_q[15:7] : 9'h000;
  assign mem       = commit ? mir_q[6:4] : 3'b000;
  assign b_sel     = mir_q[3:0];
  assign mpc       = mpc_q;
  assign n_flag    = n_flag_q;
  assign z_flag    = z_flag_q;
  assign halted    = halted_q;
  assign ucount    = ucount_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_micro_sequencer: directed scenarios plus randomized run against a
// behavioural model of the sequencer (phase, MIR, address, count, flags).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        n_in = 1'b0;
  logic        z_in = 1'b0;
  logic [7:0]  mbr_in = 8'h00;
  logic [35:0] cs_data;
  logic [8:0]  mpc;
  logic [7:0]  select;
  logic [8:0]  c_en;
  logic [2:0]  mem;
  logic [3:0]  b_sel;
  logic        n_flag, z_flag, halted;
  logic [31:0] ucount;
  logic [1:0]  state_dbg;

  logic [35:0] cs_mem [512];

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  assign cs_data = cs_mem[mpc];

  micro_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .cs_data(cs_data), .N(n_in), .Z(z_in), .mbr(mbr_in),
    .mpc(mpc), .select(select), .c_en(c_en), .mem(mem), .b_sel(b_sel),
    .n_flag(n_flag), .z_flag(z_flag), .halted(halted), .ucount(ucount),
    .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;
  int          m_phase;
  logic [35:0] m_mir;
  logic [8:0]  m_mpc;
  logic [31:0] m_cnt;
  logic        m_n, m_z;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_mir   = '0;
    m_mpc   = '0;
    m_cnt   = '0;
    m_n     = 1'b0;
    m_z     = 1'b0;
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_edge();
    logic [8:0] addr;
    logic       stop;
    if (rst) begin
      model_reset();
    end else if (m_phase == P_IDLE) begin
      if (start) m_phase = P_FETCH;
    end else if (m_phase == P_FETCH) begin
      m_mir   = cs_mem[m_mpc];
      m_phase = P_EXEC;
    end else if (m_phase == P_EXEC && !stall) begin
      addr = m_mir[35:27];
      if ((m_mir[25] && n_in) || (m_mir[24] && z_in)) addr = addr | 9'h100;
`ifdef MICRO_SEQUENCER_JMPC_EN
      if (m_mir[26]) addr = addr | {1'b0, mbr_in};
      stop = (m_mir[35:27] == 9'h1FF) && !m_mir[26] && !m_mir[25] && !m_mir[24];
`else
      stop = (m_mir[35:27] == 9'h1FF) && !m_mir[25] && !m_mir[24];
`endif
      m_n     = n_in;
      m_z     = z_in;
      m_cnt   = m_cnt + 1;
      m_mpc   = addr;
      m_phase = stop ? P_HALT : P_FETCH;
    end
  endtask

  // Expected {mpc, select, c_en, mem, b_sel, n, z, halted, ucount}.
  function automatic logic [67:0] exp_vec();
    logic [7:0] sel;
    logic [8:0] ce;
    logic [2:0] mm;
    sel = (m_phase == P_EXEC) ? m_mir[23:16] : 8'h10;
    ce  = (m_phase == P_EXEC && !stall) ? m_mir[15:7] : 9'h0;
    mm  = (m_phase == P_EXEC && !stall) ? m_mir[6:4] : 3'h0;
    return {m_mpc, sel, ce, mm, m_mir[3:0], m_n, m_z, (m_phase == P_HALT), m_cnt};
  endfunction

  function automatic logic [35:0] mk(input logic [8:0] na, input logic jmpc,
                                     input logic jamn, input logic jamz,
                                     input logic [7:0] alu, input logic [8:0] c,
                                     input logic [2:0] m, input logic [3:0] b);
    return {na, jmpc, jamn, jamz, alu, c, m, b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_exec();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    n_checks++; if (select !== 8'h10) $display("FAIL rst_select: got %b want 00010000", select); else n_pass++;
    n_checks++; if ({c_en, mem} !== 12'h0) $display("FAIL rst_cen_mem: got %h/%h want 0/0", c_en, mem); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if ({mpc, ucount, halted, n_flag, z_flag, b_sel} !== '0)
      $display("FAIL rst_regs: mpc=%h ucount=%h halted=%b n=%b z=%b b=%h want all 0",
               mpc, ucount, halted, n_flag, z_flag, b_sel);
    else n_pass++;
  endtask

  task automatic test_basic();
    cs_mem[0] = mk(9'h005, 0, 0, 0, 8'b00111100, 9'h001, 3'b000, 4'h3);
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    #1;
    n_checks++; if (select !== 8'h10 || c_en !== 9'h0) $display("FAIL basic_fetch: select=%b c_en=%h want 00010000/000", select, c_en); else n_pass++;
    cycle();
    #1;
    n_checks++; if (select !== 8'b00111100) $display("FAIL basic_select: got %b want 00111100", select); else n_pass++;
    n_checks++; if (c_en !== 9'h001 || b_sel !== 4'h3) $display("FAIL basic_cen: c_en=%h b=%h want 001/3", c_en, b_sel); else n_pass++;
    n_checks++; if (ucount !== 32'd0) $display("FAIL basic_ucount_pre: got %0d want 0", ucount); else n_pass++;
    cycle();
    #1;
    n_checks++; if (mpc !== 9'h005) $display("FAIL basic_mpc: got %h want 005", mpc); else n_pass++;
    n_checks++; if (ucount !== 32'd1) $display("FAIL basic_ucount: got %0d want 1", ucount); else n_pass++;
  endtask

  task automatic test_jamz();
    cs_mem[0] = mk(9'h010, 0, 0, 1, 8'h3C, 9'h000, 3'b000, 4'h0);
    do_reset();
    run_to_exec();
    z_in = 1'b1; n_in = 1'b0;
    cycle();
    #1;
    n_checks++; if (mpc !== 9'h110 || z_flag !== 1'b1) $display("FAIL jamz_taken: mpc=%h z=%b want 110/1", mpc, z_flag); else n_pass++;
    do_reset();
    run_to_exec();
    z_in = 1'b0;
    cycle();
    #1;
    n_checks++; if (mpc !== 9'h010 || z_flag !== 1'b0) $display("FAIL jamz_not: mpc=%h z=%b want 010/0", mpc, z_flag); else n_pass++;
  endtask

  task automatic test_jmpc();
    logic [8:0] want;
`ifdef MICRO_SEQUENCER_JMPC_EN
    want = 9'h060;
`else
    want = 9'h000;
`endif
    cs_mem[0] = mk(9'h000, 1, 0, 0, 8'h14, 9'h000, 3'b000, 4'h0);
    do_reset();
    run_to_exec();
    mbr_in = 8'h60;
    cycle();
    #1;
    n_checks++; if (mpc !== want) $display("FAIL jmpc: got %h want %h", mpc, want); else n_pass++;
    mbr_in = 8'h00;
  endtask

  task automatic test_stall();
    cs_mem[0] = mk(9'h007, 0, 0, 0, 8'h35, 9'h1AB, 3'b101, 4'h9);
    cs_mem[7] = mk(9'h008, 0, 0, 0, 8'h35, 9'h0FF, 3'b011, 4'h1);
    do_reset();
    run_to_exec();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (c_en !== 9'h0 || mem !== 3'h0 || mpc !== 9'h0 || ucount !== 32'd0 || select !== 8'h35)
        $display("FAIL stall_hold%0d: c_en=%h mem=%h mpc=%h ucount=%0d select=%h want 0/0/0/0/35",
                 i, c_en, mem, mpc, ucount, select);
      else n_pass++;
      cycle();
    end
    stall = 1'b0;
    #1;
    n_checks++; if (c_en !== 9'h1AB || mem !== 3'b101) $display("FAIL stall_release: c_en=%h mem=%h want 1ab/5", c_en, mem); else n_pass++;
    cycle();
    #1;
    n_checks++; if (ucount !== 32'd1 || mpc !== 9'h007) $display("FAIL stall_commit: ucount=%0d mpc=%h want 1/007", ucount, mpc); else n_pass++;
    n_checks++; if (c_en !== 9'h0 || mem !== 3'h0) $display("FAIL stall_once: c_en=%h mem=%h want 0/0", c_en, mem); else n_pass++;
  endtask

  task automatic test_halt();
    cs_mem[0] = mk(9'h1FF, 0, 0, 0, 8'h3C, 9'h003, 3'b001, 4'h2);
    do_reset();
    run_to_exec();
    cycle();
    #1;
    n_checks++; if (halted !== 1'b1 || mpc !== 9'h1FF || ucount !== 32'd1)
      $display("FAIL halt_enter: halted=%b mpc=%h ucount=%0d want 1/1ff/1", halted, mpc, ucount);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      start = i[0]; stall = i[1];
      cycle();
      #1;
      n_checks++;
      if (halted !== 1'b1 || mpc !== 9'h1FF || ucount !== 32'd1 || select !== 8'h10 || c_en !== 9'h0)
        $display("FAIL halt_hold%0d: halted=%b mpc=%h ucount=%0d select=%h c_en=%h", i, halted, mpc, ucount, select, c_en);
      else n_pass++;
    end
    start = 1'b0; stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (halted !== 1'b0 || mpc !== 9'h0) $display("FAIL halt_reset: halted=%b mpc=%h want 0/000", halted, mpc); else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_async_reset();
    cs_mem[0] = mk(9'h001, 0, 0, 0, 8'h11, 9'h002, 3'b010, 4'h4);
    cs_mem[1] = mk(9'h002, 0, 0, 0, 8'h3F, 9'h1FF, 3'b111, 4'h5);
    do_reset();
    run_to_exec();
    cycle();  // commit word 0
    cycle();  // fetch word 1
    stall = 1'b1;
    #1;
    n_checks++; if (select !== 8'h3F || ucount !== 32'd1) $display("FAIL arst_pre: select=%h ucount=%0d want 3f/1", select, ucount); else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (select !== 8'h10 || c_en !== 9'h0 || mem !== 3'h0 || ucount !== 32'd0)
      $display("FAIL arst_mid: select=%b c_en=%h mem=%h ucount=%0d want 00010000/0/0/0", select, c_en, mem, ucount);
    else n_pass++;
    model_reset();
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (c_en !== 9'h0 || mpc !== 9'h0 || ucount !== 32'd0) $display("FAIL arst_after: c_en=%h mpc=%h ucount=%0d want 0/0/0", c_en, mpc, ucount); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] w;
    logic [67:0] got, want;
    for (int i = 0; i < 512; i++) begin
      w = {$urandom, $urandom};
      if ($urandom_range(0, 11) == 0) w[35:24] = {9'h1FF, 3'b000};
      cs_mem[i] = w[35:0];
    end
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ((m_phase == P_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      start  = ($urandom_range(0, 3) == 0);
      stall  = ($urandom_range(0, 9) < 3);
      n_in   = $urandom_range(0, 1);
      z_in   = $urandom_range(0, 1);
      mbr_in = 8'($urandom_range(0, 255));
      #1;
      got  = {mpc, select, c_en, mem, b_sel, n_flag, z_flag, halted, ucount};
      want = exp_vec();
      n_checks++;
      if (got !== want) $display("FAIL random_%0d: got %h want %h", i, got, want);
      else n_pass++;
      cycle();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 512; i++) cs_mem[i] = '0;
    model_reset();
    test_reset();
    test_basic();
    test_jamz();
    test_jmpc();
    test_stall();
    test_halt();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
